// File: rtl/uart_mmio_if.sv
// Register-bus side of the UART: TX byte push, RX pop and the packed status/data word.
interface uart_mmio_if;
  logic [7:0]  dataIn;
  logic        write;
  logic        read;
  logic [15:0] dataOut;

  modport master (output dataIn, output write, output read, input dataOut);
  modport slave  (input dataIn, input write, input read, output dataOut);
endinterface

// File: rtl/uart_mmio.sv
// 8N1 UART with TX/RX byte FIFOs behind a strobe-style register bus.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  uart_mmio_if.slave bus,
  input  logic       RX,
  output logic       TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0]   tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line, tx_bit_end;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0]   rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  logic          rx_p0, rx_p1, rx_p2;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_bit_end, rx_stop_smp, rx_overrun, rx_frame_err;

  assign tx_full    = (tx_count == FULL_CNT);
  assign tx_empty   = (tx_count == '0);
  assign tx_push    = bus.write && !tx_full;
  assign tx_bit_end = (tx_cnt == BIT_LAST);
  // Popping at the end of STOP is what makes consecutive frames gap-free.
  assign tx_pop     = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_bit_end));

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr] <= bus.dataIn;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_shift <= tx_mem[tx_rd];
          tx_line  <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= S_START;
        end
        S_START: if (tx_bit_end) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_line  <= tx_shift[0];
          tx_state <= S_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        S_DATA: if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_line  <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_line  <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        S_STOP: if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            tx_line  <= 1'b0;
            tx_state <= S_START;
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign TX = tx_line;

  // Synchronizer stages p0/p1; p2 only feeds falling-edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_empty    = (rx_count == '0);
  assign rx_bit_end  = (rx_cnt == BIT_LAST);
  assign rx_stop_smp = (rx_state == S_STOP) && rx_bit_end;
  assign rx_push     = rx_stop_smp && rx_p1 && !rx_full;
  assign rx_pop      = bus.read && !rx_empty;

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_count     <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_count     <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      rx_overrun   <= (rx_stop_smp && rx_p1 && rx_full) || (rx_overrun && !bus.read);
      rx_frame_err <= (rx_stop_smp && !rx_p1) || (rx_frame_err && !bus.read);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: if (rx_p2 && !rx_p1) begin
          rx_cnt   <= '0;
          rx_state <= S_START;
        end
        S_START: if (rx_cnt == BIT_HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_p1 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_DATA: if (rx_bit_end) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_p1, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_STOP: if (rx_bit_end) begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dataOut = {!rx_empty, tx_full, tx_empty, rx_overrun, rx_frame_err, 3'b000,
                        rx_empty ? 8'h00 : rx_mem[rx_rd]};
endmodule
